// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch block.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam int INSTR_BYTES = 2;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_ADDR_W  = 16;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO holding {pc, instruction} pairs between the memory read and decode.
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_pc_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic [1:0]        count_o,
  output logic [ADDR_W-1:0] head_pc_o,
  output logic [DATA_W-1:0] head_data_o
);

  logic [ADDR_W-1:0] pc_q   [2];
  logic [DATA_W-1:0] data_q [2];
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic [1:0]        count_q, count_d;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush_i) begin
      wr_d    = 1'b0;
      rd_d    = 1'b0;
      count_d = 2'd0;
    end else begin
      if (push_i) wr_d = ~wr_q;
      if (pop_i)  rd_d = ~rd_q;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      count_q <= 2'd0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Entry storage carries no reset; occupancy alone says what is meaningful.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      pc_q[wr_q]   <= push_pc_i;
      data_q[wr_q] <= push_data_i;
    end
  end

  assign count_o     = count_q;
  assign head_pc_o   = pc_q[rd_q];
  assign head_data_o = data_q[rd_q];

endmodule

// File: rtl/instr_fetch_mem.sv
// Instruction memory with PC sequencer, IDLE/RUN/FAULT control and a 2-entry
// output buffer feeding decode over valid/ready.
module instr_fetch_mem
  import fetch_pkg::*;
#(
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DEPTH    = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              start,
  input  logic              stop,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              fault
);

  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(INSTR_BYTES);

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] rd_pc_q;

  logic [ADDR_W-1:0] pc_word, load_word;
  logic              pc_bad, load_we, issue, flush, pop, room;
  logic [2:0]        occ;
  logic [1:0]        buf_count;
  logic [ADDR_W-1:0] head_pc;
  logic [DATA_W-1:0] head_data;

  assign pc_word   = pc_q >> 1;
  assign load_word = load_addr >> 1;
  assign pc_bad    = pc_q[0] | (pc_word >= DEPTH_A);
  assign load_we   = rst && (state_q == IDLE) && load_en && (load_word < DEPTH_A);

  assign instr_valid = (buf_count != 2'd0);
  assign pop         = instr_valid & instr_ready;
  // Space left once this cycle's pop and the in-flight read are accounted for.
  assign occ  = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign room = (occ < 3'd2);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    issue   = 1'b0;
    flush   = 1'b0;
    if (stop) begin
      state_d = IDLE;
      flush   = 1'b1;
    end else if (redirect_valid && (state_q != IDLE)) begin
      state_d = RUN;
      pc_d    = redirect_pc;
      flush   = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (start) state_d = RUN;
        RUN: begin
          if (room) begin
            if (pc_bad) begin
              state_d = FAULT;
            end else begin
              issue = 1'b1;
              pc_d  = pc_q + STEP;
            end
          end
        end
        default: state_d = state_q;
      endcase
    end
    inflight_d = issue;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
    end
  end

  // Program array and its synchronous read port; never cleared by reset.
  always_ff @(posedge clk) begin
    if (load_we) mem_q[load_word[IDX_W-1:0]] <= load_data;
    if (issue) begin
      rdata_q <= mem_q[pc_word[IDX_W-1:0]];
      rd_pc_q <= pc_q;
    end
  end

  fetch_skid_buf #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_pc_i   (rd_pc_q),
    .push_data_i (rdata_q),
    .pop_i       (pop),
    .flush_i     (flush),
    .count_o     (buf_count),
    .head_pc_o   (head_pc),
    .head_data_o (head_data)
  );

  assign instr_data = instr_valid ? head_data : '0;
  assign instr_pc   = instr_valid ? head_pc : '0;
  assign fault      = (state_q == FAULT);

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed bench: a DEPTH=64 and a DEPTH=8 instance share every input.
module tb_instr_fetch_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en;
  logic [15:0] load_addr;
  logic [15:0] load_data;
  logic        start;
  logic        stop;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        instr_ready;

  logic        v, f, v8, f8;
  logic [15:0] d, p, d8, p8;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] prog [9] = '{16'hF120, 16'hF121, 16'hF343, 16'hF322,
                            16'hA004, 16'hA005, 16'hA006, 16'hA007, 16'hB008};
  logic [15:0] exp_rs [3] = '{16'hF120, 16'h1234, 16'hF343};

  always #5 clk = ~clk;

  instr_fetch_mem #(.DATA_W(16), .ADDR_W(16), .DEPTH(64), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .stop(stop), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(v), .instr_ready(instr_ready), .instr_data(d), .instr_pc(p), .fault(f)
  );

  instr_fetch_mem #(.DATA_W(16), .ADDR_W(16), .DEPTH(8), .RESET_PC(16'h0000)) dut8 (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .stop(stop), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(v8), .instr_ready(instr_ready), .instr_data(d8), .instr_pc(p8), .fault(f8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart(input logic rdy);
    rst = 1'b0; instr_ready = rdy;
    tick();
    rst = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0; start = 1'b0;
    stop = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    tick(); tick();
    n_tests++; if (v !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", v); end
    n_tests++; if (d !== 16'h0) begin n_fail++; $display("FAIL reset_data got %h want 0000", d); end
    n_tests++; if (p !== 16'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0000", p); end
    n_tests++; if (f !== 1'b0) begin n_fail++; $display("FAIL reset_fault got %b want 0", f); end
    n_tests++; if (f8 !== 1'b0) begin n_fail++; $display("FAIL reset_fault8 got %b want 0", f8); end
    rst = 1'b1;
  endtask

  task automatic test_load_run();
    load_en = 1'b1; load_addr = 16'h0000; load_data = 16'hDEAD;
    tick();
    for (int i = 1; i < 9; i++) begin
      load_addr = 16'(2 * i); load_data = prog[i];
      tick();
    end
    // Final word goes in together with start; the first fetch must see it.
    load_addr = 16'h0000; load_data = prog[0]; start = 1'b1; instr_ready = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    n_tests++; if (v !== 1'b0) begin n_fail++; $display("FAIL run_lat0 valid got %b want 0", v); end
    tick();
    n_tests++; if (v !== 1'b0) begin n_fail++; $display("FAIL run_lat1 valid got %b want 0", v); end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_tests++; if (v !== 1'b1) begin n_fail++; $display("FAIL run_valid[%0d] got %b want 1", k, v); end
      n_tests++; if (p !== 16'(2 * k)) begin n_fail++; $display("FAIL run_pc[%0d] got %h want %h", k, p, 16'(2 * k)); end
      n_tests++; if (d !== prog[k]) begin n_fail++; $display("FAIL run_data[%0d] got %h want %h", k, d, prog[k]); end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_backpressure();
    restart(1'b0);
    tick(); tick();
    n_tests++; if (v !== 1'b1 || p !== 16'h0 || d !== 16'hF120) begin
      n_fail++; $display("FAIL bp_first got v=%b pc=%h d=%h want v=1 pc=0000 d=F120", v, p, d); end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_tests++; if (v !== 1'b1 || p !== 16'h0 || d !== 16'hF120) begin
        n_fail++; $display("FAIL bp_hold[%0d] got v=%b pc=%h d=%h want v=1 pc=0000 d=F120", k, v, p, d); end
    end
    instr_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick();
      n_tests++; if (v !== 1'b1 || p !== 16'(2 * k) || d !== prog[k]) begin
        n_fail++; $display("FAIL bp_drain[%0d] got v=%b pc=%h d=%h want v=1 pc=%h d=%h", k, v, p, d, 16'(2 * k), prog[k]); end
    end
  endtask

  task automatic test_redirect();
    restart(1'b0);
    tick(); tick(); tick();
    n_tests++; if (v !== 1'b1 || p !== 16'h0) begin
      n_fail++; $display("FAIL rd_full got v=%b pc=%h want v=1 pc=0000", v, p); end
    redirect_valid = 1'b1; redirect_pc = 16'h0010;
    tick();
    redirect_valid = 1'b0;
    n_tests++; if (v !== 1'b0) begin n_fail++; $display("FAIL rd_flush valid got %b want 0", v); end
    tick();
    n_tests++; if (v !== 1'b0) begin n_fail++; $display("FAIL rd_gap valid got %b want 0", v); end
    tick();
    n_tests++; if (v !== 1'b1 || p !== 16'h0010 || d !== 16'hB008) begin
      n_fail++; $display("FAIL rd_target got v=%b pc=%h d=%h want v=1 pc=0010 d=B008", v, p, d); end
  endtask

  task automatic test_fault();
    restart(1'b1);
    tick();
    for (int k = 0; k < 8; k++) begin
      tick();
      n_tests++; if (v8 !== 1'b1 || p8 !== 16'(2 * k) || d8 !== prog[k]) begin
        n_fail++; $display("FAIL flt_run[%0d] got v=%b pc=%h d=%h want v=1 pc=%h d=%h", k, v8, p8, d8, 16'(2 * k), prog[k]); end
      n_tests++; if (f8 !== (k == 7)) begin
        n_fail++; $display("FAIL flt_flag[%0d] got %b want %b", k, f8, (k == 7)); end
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++; if (v8 !== 1'b0 || f8 !== 1'b1) begin
        n_fail++; $display("FAIL flt_hold[%0d] got v=%b f=%b want v=0 f=1", k, v8, f8); end
    end
    redirect_valid = 1'b1; redirect_pc = 16'h0003;
    tick();
    redirect_valid = 1'b0;
    n_tests++; if (f8 !== 1'b0) begin n_fail++; $display("FAIL flt_clear3 got %b want 0", f8); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++; if (v8 !== 1'b0 || f8 !== 1'b1) begin
        n_fail++; $display("FAIL flt_misalign[%0d] got v=%b f=%b want v=0 f=1", k, v8, f8); end
    end
    redirect_valid = 1'b1; redirect_pc = 16'h0000;
    tick();
    redirect_valid = 1'b0;
    n_tests++; if (f8 !== 1'b0) begin n_fail++; $display("FAIL flt_clear0 got %b want 0", f8); end
    tick(); tick();
    n_tests++; if (v8 !== 1'b1 || p8 !== 16'h0 || d8 !== 16'hF120 || f8 !== 1'b0) begin
      n_fail++; $display("FAIL flt_resume got v=%b pc=%h d=%h f=%b want v=1 pc=0000 d=F120 f=0", v8, p8, d8, f8); end
  endtask

  task automatic test_stop_reset();
    restart(1'b1);
    tick(); tick();
    n_tests++; if (v !== 1'b1 || p !== 16'h0) begin
      n_fail++; $display("FAIL sp_run got v=%b pc=%h want v=1 pc=0000", v, p); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_tests++; if (v !== 1'b0 || d !== 16'h0 || f !== 1'b0) begin
      n_fail++; $display("FAIL sp_stop got v=%b d=%h f=%b want v=0 d=0000 f=0", v, d, f); end
    load_en = 1'b1; load_addr = 16'h0002; load_data = 16'h1234;
    tick();
    load_en = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 16'h0000;
    tick();
    redirect_valid = 1'b0;
    tick(); tick();
    n_tests++; if (v !== 1'b0) begin n_fail++; $display("FAIL sp_idle_redirect valid got %b want 0", v); end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    n_tests++; if (v !== 1'b1) begin n_fail++; $display("FAIL sp_resume valid got %b want 1", v); end
    rst = 1'b0;
    tick();
    n_tests++; if (v !== 1'b0 || d !== 16'h0 || p !== 16'h0 || f !== 1'b0) begin
      n_fail++; $display("FAIL sp_rst got v=%b d=%h pc=%h f=%b want all 0", v, d, p, f); end
    rst = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++; if (v !== 1'b1 || p !== 16'(2 * k) || d !== exp_rs[k]) begin
        n_fail++; $display("FAIL sp_restart[%0d] got v=%b pc=%h d=%h want v=1 pc=%h d=%h", k, v, p, d, 16'(2 * k), exp_rs[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_load_run();
    test_backpressure();
    test_redirect();
    test_fault();
    test_stop_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d tests", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
